// File: rtl/serial_word_rx_if.sv
// rtl/serial_word_rx_if.sv - serial bit input and word output handshake bundle for serial_word_rx
interface serial_word_rx_if #(
  parameter int WIDTH = 8
);
  logic             in;
  logic             in_en;
  logic [WIDTH-1:0] word_data;
  logic             word_valid;
  logic             word_ready;

  modport master (
    output in, in_en, word_ready,
    input  word_data, word_valid
  );

  modport slave (
    input  in, in_en, word_ready,
    output word_data, word_valid
  );
endinterface

// File: rtl/serial_word_rx.sv
// rtl/serial_word_rx.sv - sync-hunting serial deserialiser with valid/ready word output
module serial_word_rx #(
  parameter int                WIDTH        = 8,
  parameter int                SYNC_W       = 8,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5,
  parameter int                FRAME_WORDS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  resync,
  output logic                  locked,
  output logic [7:0]            overflow_cnt,
  serial_word_rx_if.slave       bus
);
  localparam int BW = $clog2(WIDTH);
  localparam int FW = $clog2(SYNC_W + 1);
  localparam int WW = $clog2(FRAME_WORDS + 1);

  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(SYNC_W);
  localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t            state, state_n;
  logic [SYNC_W-1:0] sync_sr, sync_sr_n, sync_shift;
  logic [FW-1:0]     fill, fill_n;
  logic [WIDTH-1:0]  data_sr, data_sr_n, data_shift;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic [WW-1:0]     word_cnt, word_cnt_n;
  logic [WIDTH-1:0]  word_data_q, word_data_n;
  logic              word_valid_q, word_valid_n;
  logic [7:0]        ovf_q, ovf_n;
  logic              xfer;

  assign xfer           = word_valid_q & bus.word_ready;
  assign sync_shift     = {sync_sr[SYNC_W-2:0], bus.in};
  assign data_shift     = {data_sr[WIDTH-2:0], bus.in};
  assign bus.word_data  = word_data_q;
  assign bus.word_valid = word_valid_q;
  assign overflow_cnt   = ovf_q;
  assign locked         = (state == COLLECT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= HUNT;
      sync_sr      <= '0;
      fill         <= '0;
      data_sr      <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      ovf_q        <= '0;
    end else begin
      state        <= state_n;
      sync_sr      <= sync_sr_n;
      fill         <= fill_n;
      data_sr      <= data_sr_n;
      bit_cnt      <= bit_cnt_n;
      word_cnt     <= word_cnt_n;
      word_data_q  <= word_data_n;
      word_valid_q <= word_valid_n;
      ovf_q        <= ovf_n;
    end
  end

  always_comb begin
    state_n      = state;
    sync_sr_n    = sync_sr;
    fill_n       = fill;
    data_sr_n    = data_sr;
    bit_cnt_n    = bit_cnt;
    word_cnt_n   = word_cnt;
    word_data_n  = word_data_q;
    word_valid_n = word_valid_q & ~bus.word_ready;
    ovf_n        = ovf_q;

    if (resync) begin
      // the in_en bit on a resync cycle is deliberately ignored
      state_n    = HUNT;
      sync_sr_n  = '0;
      fill_n     = '0;
      data_sr_n  = '0;
      bit_cnt_n  = '0;
      word_cnt_n = '0;
    end else if (bus.in_en) begin
      case (state)
        HUNT: begin
          sync_sr_n = sync_shift;
          fill_n    = (fill == FILL_FULL) ? fill : fill + 1'b1;
          if (sync_shift == SYNC_PATTERN && fill_n == FILL_FULL) begin
            state_n    = COLLECT;
            bit_cnt_n  = '0;
            word_cnt_n = '0;
          end
        end
        COLLECT: begin
          data_sr_n = data_shift;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_n = '0;
            if (!word_valid_q || xfer) begin
              word_data_n  = data_shift;
              word_valid_n = 1'b1;
            end else begin
              ovf_n = (ovf_q == 8'hFF) ? ovf_q : ovf_q + 8'd1;
            end
            if (word_cnt == WORD_LAST) begin
              // a fresh hunt must see a full SYNC_W bits before it can match
              state_n    = HUNT;
              sync_sr_n  = '0;
              fill_n     = '0;
              word_cnt_n = '0;
            end else begin
              word_cnt_n = word_cnt + 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_word_rx.sv
// tb/tb_serial_word_rx.sv - directed and randomized checks of serial_word_rx against a queue-based model
module tb_serial_word_rx;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       resync = 1'b0;
  logic       locked;
  logic [7:0] overflow_cnt;

  serial_word_rx_if #(.WIDTH(8)) bus ();

  serial_word_rx #(
    .WIDTH(8), .SYNC_W(8), .SYNC_PATTERN(8'hA5), .FRAME_WORDS(4)
  ) dut (
    .clk(clk), .reset(reset), .resync(resync),
    .locked(locked), .overflow_cnt(overflow_cnt), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: bit queues since the last hunt/collect entry
  bit       hq[$];
  bit       wq[$];
  int       m_words;
  bit       m_locked;
  bit       m_valid;
  bit [7:0] m_data;
  int       m_ovf;

  bit [7:0] got[$];
  bit [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit b, input bit en, input bit rdy, input bit rs, input bit rst);
    int v;
    if (rst) begin
      hq.delete(); wq.delete();
      m_words = 0; m_locked = 0; m_valid = 0; m_data = 0; m_ovf = 0;
      return;
    end
    if (m_valid && rdy) m_valid = 0;
    if (rs) begin
      m_locked = 0; hq.delete(); wq.delete(); m_words = 0;
    end else if (en) begin
      if (!m_locked) begin
        hq.push_back(b);
        if (hq.size() > 8) void'(hq.pop_front());
        v = 0;
        foreach (hq[i]) v = v * 2 + hq[i];
        if (hq.size() == 8 && v == 8'hA5) begin
          m_locked = 1; wq.delete(); m_words = 0;
        end
      end else begin
        wq.push_back(b);
        if (wq.size() == 8) begin
          v = 0;
          foreach (wq[i]) v = v * 2 + wq[i];
          wq.delete();
          if (!m_valid) begin
            m_valid = 1; m_data = v[7:0];
          end else if (m_ovf < 255) begin
            m_ovf++;
          end
          m_words++;
          if (m_words == 4) begin
            m_locked = 0; hq.delete(); m_words = 0;
          end
        end
      end
    end
  endtask

  task automatic cyc(input logic b, input logic en, input logic rdy, input logic rs);
    bus.in = b; bus.in_en = en; bus.word_ready = rdy; resync = rs;
    if (!reset && bus.word_valid === 1'b1 && rdy) got.push_back(bus.word_data);
    @(posedge clk);
    model_step(b, en, rdy, rs, reset);
    #1;
    chk("word_valid", bus.word_valid, m_valid);
    chk("word_data", bus.word_data, m_data);
    chk("locked", locked, m_locked);
    chk("overflow_cnt", overflow_cnt, m_ovf);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit toggle, input logic rdy);
    for (int i = 7; i >= 0; i--) begin
      if (toggle) cyc(1'($urandom), 1'b0, rdy, 1'b0);
      cyc(v[i], 1'b1, rdy, 1'b0);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic check_got(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk({tag, "_word"}, got[i], exp_q[i]);
    got.delete();
  endtask

  initial begin
    bit [7:0] w1, w2;
    bus.in = 1'b0; bus.in_en = 1'b0; bus.word_ready = 1'b0;

    do_reset();
    chk("reset_valid", bus.word_valid, 1'b0);
    chk("reset_data", bus.word_data, 8'h00);
    chk("reset_locked", locked, 1'b0);
    chk("reset_ovf", overflow_cnt, 8'h00);

    // basic frame
    got.delete();
    send_byte(8'hA5, 0, 1'b1);
    chk("locked_after_sync", locked, 1'b1);
    send_byte(8'h3C, 0, 1'b1);
    send_byte(8'h81, 0, 1'b1);
    send_byte(8'hFF, 0, 1'b1);
    send_byte(8'h00, 0, 1'b1);
    chk("locked_after_frame", locked, 1'b0);
    idle(3, 1'b1);
    exp_q = '{8'h3C, 8'h81, 8'hFF, 8'h00};
    check_got("basic");
    chk("basic_ovf", overflow_cnt, 8'h00);

    // preamble bits before sync
    cyc(1'b1, 1'b1, 1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b1, 1'b0);
    send_byte(8'hA5, 0, 1'b1);
    send_byte(8'h5A, 0, 1'b1);
    send_byte(8'h12, 0, 1'b1);
    send_byte(8'h34, 0, 1'b1);
    send_byte(8'h56, 0, 1'b1);
    idle(2, 1'b1);
    exp_q = '{8'h5A, 8'h12, 8'h34, 8'h56};
    check_got("align");

    // backpressure over a whole frame
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    send_byte(8'h33, 0, 1'b0);
    send_byte(8'h44, 0, 1'b0);
    idle(2, 1'b0);
    chk("bp_data", bus.word_data, 8'h11);
    chk("bp_valid", bus.word_valid, 1'b1);
    chk("bp_ovf", overflow_cnt, 8'd3);
    idle(3, 1'b1);
    exp_q = '{8'h11};
    check_got("bp");

    // in_en toggling
    exp_q.delete();
    send_byte(8'hA5, 1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      w1 = 8'($urandom);
      exp_q.push_back(w1);
      send_byte(w1, 1, 1'b1);
    end
    idle(2, 1'b1);
    check_got("toggle");

    // resync mid word
    w1 = 8'($urandom);
    w2 = 8'($urandom);
    send_byte(8'hA5, 0, 1'b1);
    send_byte(w1, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b1, 1'b0); cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("pre_resync_locked", locked, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("resync_locked", locked, 1'b0);
    idle(10, 1'b1);
    send_byte(8'hA5, 0, 1'b1);
    send_byte(w2, 0, 1'b1);
    send_byte(8'h01, 0, 1'b1);
    send_byte(8'h02, 0, 1'b1);
    send_byte(8'h03, 0, 1'b1);
    idle(2, 1'b1);
    exp_q = '{w1, w2, 8'h01, 8'h02, 8'h03};
    check_got("resync");

    // reset with a pending word mid-frame
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h77, 0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("pre_reset_valid", bus.word_valid, 1'b1);
    do_reset();
    chk("mid_reset_valid", bus.word_valid, 1'b0);
    chk("mid_reset_data", bus.word_data, 8'h00);
    chk("mid_reset_locked", locked, 1'b0);
    got.delete();
    send_byte(8'hA5, 0, 1'b1);
    send_byte(8'hC3, 0, 1'b1);
    send_byte(8'h3C, 0, 1'b1);
    send_byte(8'h99, 0, 1'b1);
    send_byte(8'h66, 0, 1'b1);
    idle(2, 1'b1);
    exp_q = '{8'hC3, 8'h3C, 8'h99, 8'h66};
    check_got("post_reset");

    // randomized traffic against the model
    for (int k = 0; k < 60; k++) begin
      w1 = ($urandom_range(0, 2) == 0) ? 8'hA5 : 8'($urandom);
      for (int i = 7; i >= 0; i--)
        cyc(w1[i], 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 63) == 0));
    end
    idle(3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
